// File: rtl/ws2812b_frame_sched.sv
// WS2812B VU-meter frame scheduler: level intake, peak-marker hold/decay,
// one serializer frame per refresh tick, and a registered per-LED colour lookup.
module ws2812b_frame_sched #(
   parameter int unsigned FRAME_CYCLES     = 1666667,
   parameter int unsigned PEAK_HOLD_FRAMES = 30,
   parameter int unsigned DECAY_STEP       = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        level_valid,
   output logic        level_ready,
   input  logic [15:0] level_data,
   input  logic [15:0] max_count,
   input  logic [15:0] seg1_end,
   input  logic [15:0] seg2_end,
   input  logic [23:0] color0,
   input  logic [23:0] color1,
   input  logic [23:0] color2,
   input  logic [23:0] peak_color,
   output logic        frame_start,
   input  logic        frame_done,
   input  logic        pix_req,
   input  logic [15:0] pix_idx,
   output logic        pix_valid,
   output logic [23:0] pix_color,
   output logic [15:0] on_count,
   output logic [15:0] peak_pos,
   output logic        overrun
);

   localparam int unsigned CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
   localparam int unsigned HW = (PEAK_HOLD_FRAMES > 0) ? $clog2(PEAK_HOLD_FRAMES + 1) : 1;
   localparam logic [CW-1:0] TICK_AT   = CW'(FRAME_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(PEAK_HOLD_FRAMES);
   localparam logic [15:0]   STEP      = 16'(DECAY_STEP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LATCH,
      S_START,
      S_RUN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [15:0]   pend_q, pend_d;
   logic [15:0]   on_q, on_d;
   logic [15:0]   peak_q, peak_d;
   logic          ovr_q, ovr_d;
   logic          pv_q, pv_d;
   logic [23:0]   pc_q, pc_d;
   logic          tick;
   logic [15:0]   n_lvl;
   logic [15:0]   decayed;
   logic [23:0]   col;

   assign tick        = enable && (cnt_q == TICK_AT);
   assign level_ready = (state_q != S_LATCH);
   assign n_lvl       = (pend_q < max_count) ? pend_q : max_count;
   assign decayed     = (peak_q > STEP) ? peak_q - STEP : '0;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      pend_d      = pend_q;
      on_d        = on_q;
      peak_d      = peak_q;
      ovr_d       = ovr_q;
      frame_start = 1'b0;

      if (state_q == S_IDLE) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end

      if (level_valid && level_ready) begin
         pend_d = level_data;
      end

      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!enable)   state_d = S_IDLE;
            else if (tick) state_d = S_LATCH;
         end
         S_LATCH: begin
            state_d = S_START;
            on_d    = n_lvl;
            if (n_lvl >= peak_q) begin
               peak_d = n_lvl;
               hold_d = HOLD_INIT;
            end else if (hold_q != '0) begin
               hold_d = hold_q - 1'b1;
            end else begin
               peak_d = (decayed > n_lvl) ? decayed : n_lvl;
            end
         end
         S_START: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else begin
               frame_start = 1'b1;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            // a tick here is dropped; the running frame always completes
            if (tick) ovr_d = 1'b1;
            if (frame_done) state_d = enable ? S_WAIT : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      if (pix_idx >= max_count) begin
         col = '0;
      end else if (({1'b0, pix_idx} + 17'd1 == {1'b0, peak_q}) && (peak_q > on_q)) begin
         col = peak_color;
      end else if (pix_idx >= on_q) begin
         col = '0;
      end else if (pix_idx < seg1_end) begin
         col = color0;
      end else if (pix_idx < seg2_end) begin
         col = color1;
      end else begin
         col = color2;
      end
      pv_d = pix_req;
      pc_d = pix_req ? col : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         pend_q  <= '0;
         on_q    <= '0;
         peak_q  <= '0;
         ovr_q   <= 1'b0;
         pv_q    <= 1'b0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         on_q    <= on_d;
         peak_q  <= peak_d;
         ovr_q   <= ovr_d;
         pv_q    <= pv_d;
         pc_q    <= pc_d;
      end
   end

   assign on_count  = on_q;
   assign peak_pos  = peak_q;
   assign overrun   = ovr_q;
   assign pix_valid = pv_q;
   assign pix_color = pc_q;

endmodule

// File: tb/tb_ws2812b_frame_sched.sv
// Bench for ws2812b_frame_sched: table-driven pixel lookups, hand sequences
// for peak decay / overrun / enable / reset, and a randomized frame phase.
module tb_ws2812b_frame_sched;

   localparam int FC = 20;
   localparam int PH = 2;
   localparam int DS = 1;
   localparam logic [23:0] C0 = 24'h110000;
   localparam logic [23:0] C1 = 24'h002200;
   localparam logic [23:0] C2 = 24'h000033;
   localparam logic [23:0] PK = 24'hFFFFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        level_valid = 1'b0;
   logic        level_ready;
   logic [15:0] level_data = '0;
   logic [15:0] max_count = 16'd10;
   logic [15:0] seg1_end = 16'd4;
   logic [15:0] seg2_end = 16'd7;
   logic [23:0] color0 = C0;
   logic [23:0] color1 = C1;
   logic [23:0] color2 = C2;
   logic [23:0] peak_color = PK;
   logic        frame_start;
   logic        frame_done = 1'b0;
   logic        pix_req = 1'b0;
   logic [15:0] pix_idx = '0;
   logic        pix_valid;
   logic [23:0] pix_color;
   logic [15:0] on_count;
   logic [15:0] peak_pos;
   logic        overrun;

   ws2812b_frame_sched #(
      .FRAME_CYCLES(FC),
      .PEAK_HOLD_FRAMES(PH),
      .DECAY_STEP(DS)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .level_valid(level_valid), .level_ready(level_ready),
      .level_data(level_data), .max_count(max_count),
      .seg1_end(seg1_end), .seg2_end(seg2_end),
      .color0(color0), .color1(color1), .color2(color2),
      .peak_color(peak_color), .frame_start(frame_start),
      .frame_done(frame_done), .pix_req(pix_req), .pix_idx(pix_idx),
      .pix_valid(pix_valid), .pix_color(pix_color),
      .on_count(on_count), .peak_pos(peak_pos), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_dly = 5;
   int cd = 0;
   int m_pend = 0, m_oc = 0, m_pk = 0, m_hold = 0;

   typedef struct {
      int          idx;
      logic [23:0] exp;
   } pv_t;
   pv_t tab[22];
   int  exp2[9] = '{8, 8, 8, 7, 6, 5, 4, 3, 3};

   always @(posedge clk) cyc <= cyc + 1;

   // serializer stand-in: frame_done a fixed delay after each frame_start
   always @(negedge clk) begin
      frame_done = 1'b0;
      if (reset) begin
         cd = 0;
      end else begin
         if (cd > 0) begin
            cd--;
            if (cd == 0) frame_done = 1'b1;
         end
         if (frame_start) cd = done_dly;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_oc = 0; m_pk = 0; m_hold = 0;
   endtask

   task automatic model_frame();
      int mc = int'(max_count);
      int n  = (m_pend < mc) ? m_pend : mc;
      m_oc = n;
      if (n >= m_pk) begin
         m_pk = n;
         m_hold = PH;
      end else if (m_hold > 0) begin
         m_hold--;
      end else begin
         m_pk = (m_pk - DS > n) ? m_pk - DS : n;
      end
   endtask

   function automatic logic [23:0] ref_pix(input int idx);
      if (idx >= int'(max_count)) return '0;
      if (idx + 1 == m_pk && m_pk > m_oc) return peak_color;
      if (idx >= m_oc) return '0;
      if (idx < int'(seg1_end)) return color0;
      if (idx < int'(seg2_end)) return color1;
      return color2;
   endfunction

   task automatic wait_fs(input int lim, output int at);
      at = -1;
      for (int n = 0; n < lim; n++) begin
         @(negedge clk);
         if (frame_start) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         chk("fs_timeout", 0, 1);
      end else begin
         model_frame();
         chk("on_count_model", on_count, m_oc);
         chk("peak_pos_model", peak_pos, m_pk);
      end
   endtask

   task automatic no_fs(input int ncyc, input string nm);
      int c = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (frame_start) c++;
      end
      chk(nm, c, 0);
   endtask

   task automatic send_level(input int v);
      level_data  = 16'(v);
      level_valid = 1'b1;
      chk("level_ready", level_ready, 1);
      m_pend = v;
      @(negedge clk);
      level_valid = 1'b0;
   endtask

   task automatic run_tab(input int lo, input int hi);
      pix_req = 1'b1;
      pix_idx = 16'(tab[lo].idx);
      for (int i = lo; i < hi; i++) begin
         @(negedge clk);
         chk("tab_pix_valid", pix_valid, 1);
         chk($sformatf("tab_pix_color[%0d]", i), pix_color, tab[i].exp);
         if (i + 1 < hi) pix_idx = 16'(tab[i + 1].idx);
         else pix_req = 1'b0;
      end
      @(negedge clk);
      chk("pix_idle_valid", pix_valid, 0);
      chk("pix_idle_color", pix_color, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a0, a1, t_en;
      logic [23:0] e;

      for (int i = 0; i < 10; i++) begin
         tab[i].idx      = i;
         tab[i + 10].idx = i;
         tab[i].exp      = (i < 4) ? C0 : (i < 7) ? C1 : (i < 9) ? C2 : 24'h0;
         tab[i + 10].exp = (i < 4) ? C0 : (i == 4) ? C1 : (i == 7) ? PK : 24'h0;
      end
      tab[20].idx = 10; tab[20].exp = 24'h0;
      tab[21].idx = 9;  tab[21].exp = C2;

      repeat (3) @(negedge clk);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_on_count", on_count, 0);
      chk("rst_peak_pos", peak_pos, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_color", pix_color, 0);
      reset = 1'b0;
      model_reset();

      // steady frames at level 6
      @(negedge clk);
      enable = 1'b1;
      t_en = cyc;
      send_level(6);
      wait_fs(60, a0);
      chk("first_fs_latency", (a0 - t_en >= FC) && (a0 - t_en <= FC + 3), 1);
      chk("t1_on_count", on_count, 6);
      chk("t1_peak_pos", peak_pos, 6);
      @(negedge clk);
      chk("fs_pulse_width", frame_start, 0);
      wait_fs(40, a1);
      chk("t1_period_a", a1 - a0, FC);
      a0 = a1;
      wait_fs(40, a1);
      chk("t1_period_b", a1 - a0, FC);
      chk("t1_overrun", overrun, 0);

      // peak hold then decay
      send_level(8);
      for (int i = 0; i < 9; i++) begin
         wait_fs(40, a1);
         chk($sformatf("t2_peak[%0d]", i), peak_pos, exp2[i]);
         if (i == 0) send_level(3);
      end
      chk("t2_on_count", on_count, 3);

      // segment colours, then peak marker above the lit bar
      send_level(9);
      wait_fs(40, a1);
      chk("t4a_on_count", on_count, 9);
      chk("t4a_peak_pos", peak_pos, 9);
      run_tab(0, 10);
      send_level(5);
      repeat (3) wait_fs(40, a1);
      chk("t4b_on_count", on_count, 5);
      chk("t4b_peak_pos", peak_pos, 8);
      run_tab(10, 20);

      // level above chain length
      send_level(50);
      wait_fs(40, a1);
      chk("t3_on_count", on_count, 10);
      chk("t3_peak_pos", peak_pos, 10);
      run_tab(20, 22);

      // randomized frames against the model
      a0 = a1;
      for (int f = 0; f < 12; f++) begin
         wait_fs(40, a1);
         if (f > 0) chk("rand_period", a1 - a0, FC);
         a0 = a1;
         if ($urandom_range(0, 3) != 0) send_level(int'($urandom_range(0, 14)));
         else @(negedge clk);
         seg1_end = 16'($urandom_range(0, 10));
         seg2_end = seg1_end + 16'($urandom_range(0, 3));
         pix_req = 1'b1;
         pix_idx = 16'($urandom_range(0, 12));
         for (int k = 0; k < 4; k++) begin
            e = ref_pix(int'(pix_idx));
            @(negedge clk);
            chk("rand_pix_valid", pix_valid, 1);
            chk("rand_pix_color", pix_color, e);
            if (k < 3) pix_idx = 16'($urandom_range(0, 12));
            else pix_req = 1'b0;
         end
      end
      seg1_end = 16'd4;
      seg2_end = 16'd7;

      // serializer too slow: overrun, dropped tick
      done_dly = 30;
      wait_fs(40, a0);
      @(negedge clk);
      done_dly = 5;
      no_fs(25, "t5_no_fs_while_running");
      chk("t5_overrun", overrun, 1);
      wait_fs(40, a1);
      chk("t5_fs_after_done", a1 - a0 > 30, 1);

      // disable mid-frame
      wait_fs(40, a0);
      @(negedge clk);
      enable = 1'b0;
      no_fs(60, "t6_no_fs_disabled");
      enable = 1'b1;
      t_en = cyc;
      wait_fs(60, a1);
      chk("t6_reenable_latency", (a1 - t_en >= FC) && (a1 - t_en <= FC + 3), 1);

      // reset during RUN
      @(negedge clk);
      pix_req = 1'b1;
      pix_idx = 16'd0;
      @(negedge clk);
      pix_req = 1'b0;
      chk("t6_pix_valid_pre", pix_valid, 1);
      reset = 1'b1;
      #1;
      chk("t6_rst_frame_start", frame_start, 0);
      chk("t6_rst_on_count", on_count, 0);
      chk("t6_rst_peak_pos", peak_pos, 0);
      chk("t6_rst_overrun", overrun, 0);
      chk("t6_rst_pix_valid", pix_valid, 0);
      chk("t6_rst_pix_color", pix_color, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      t_en = cyc;
      wait_fs(60, a1);
      chk("t6_post_reset_latency", (a1 - t_en >= FC) && (a1 - t_en <= FC + 3), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
